// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions.
// Holds the word width, opcode field position and FSM state encodings.
package fetch_stage_pkg;

    localparam int WORD_W = 8;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 5;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer.
// Parks a ROM response while decode stalls.
import fetch_stage_pkg::*;

module fetch_stage_skid (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    word_t data;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end
    end

    assign dout = data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, sync ROM interface, IF/ID register.
// Absorbs decode stalls in a skid entry; flushes on redirect.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       redirect,
    input  logic [7:0] target,
    output logic [7:0] imemAddr,
    input  logic [7:0] imemData,
    output logic [7:0] pcOut,
    output logic [7:0] instOut,
    output logic       validOut
);

    fetch_state_t state, stateNext;

    word_t pcFetch, pcFetchNext;
    word_t respPc, respPcNext;
    word_t pcOutNext, instOutNext;
    logic  validNext;
    logic  skidLoad, skidClear;
    word_t skidInst;

    fetch_stage_skid u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skidLoad),
        .clear (skidClear),
        .din   (imemData),
        .dout  (skidInst)
    );

    always_comb begin
        stateNext   = state;
        pcFetchNext = pcFetch;
        respPcNext  = respPc;
        pcOutNext   = pcOut;
        instOutNext = instOut;
        validNext   = validOut;
        skidLoad    = 1'b0;
        skidClear   = 1'b0;
        if (redirect) begin
            pcFetchNext = target;
            validNext   = 1'b0;
            skidClear   = 1'b1;
            stateNext   = FILL;
        end else begin
            unique case (state)
                FILL: begin
                    if (!stall) begin
                        respPcNext  = pcFetch;
                        pcFetchNext = pcFetch + 8'd1;
                        validNext   = 1'b0;
                        stateNext   = RUN;
                    end
                end
                RUN: begin
                    if (stall) begin
                        skidLoad  = 1'b1;
                        stateNext = HOLD;
                    end else begin
                        pcOutNext   = respPc;
                        instOutNext = imemData;
                        validNext   = 1'b1;
                        respPcNext  = pcFetch;
                        pcFetchNext = pcFetch + 8'd1;
                    end
                end
                HOLD: begin
                    // ROM output here is mem[pcFetch]; it is consumed next cycle in RUN
                    if (!stall) begin
                        pcOutNext   = respPc;
                        instOutNext = skidInst;
                        validNext   = 1'b1;
                        respPcNext  = pcFetch;
                        pcFetchNext = pcFetch + 8'd1;
                        stateNext   = RUN;
                    end
                end
                default: begin
                    validNext = 1'b0;
                    stateNext = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FILL;
            pcFetch  <= RESET_PC;
            respPc   <= '0;
            pcOut    <= '0;
            instOut  <= '0;
            validOut <= 1'b0;
        end else begin
            state    <= stateNext;
            pcFetch  <= pcFetchNext;
            respPc   <= respPcNext;
            pcOut    <= pcOutNext;
            instOut  <= instOutNext;
            validOut <= validNext;
        end
    end

    assign imemAddr = pcFetch;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural sync ROM.
// ROM content: mem[i] = 8'hA0 + i (mod 256).
module tb_fetch_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetA, stallA, redirA;
    logic [7:0] targetA, addrA, dataA, pcA, instA;
    logic       validA;

    logic       resetB, stallB, redirB;
    logic [7:0] targetB, addrB, dataB, pcB, instB;
    logic       validB;

    int compared = 0;
    int mismatched = 0;

    fetch_stage #(.RESET_PC(8'h00)) dutA (
        .clock    (clock),
        .reset    (resetA),
        .stall    (stallA),
        .redirect (redirA),
        .target   (targetA),
        .imemAddr (addrA),
        .imemData (dataA),
        .pcOut    (pcA),
        .instOut  (instA),
        .validOut (validA)
    );

    fetch_stage #(.RESET_PC(8'hFE)) dutB (
        .clock    (clock),
        .reset    (resetB),
        .stall    (stallB),
        .redirect (redirB),
        .target   (targetB),
        .imemAddr (addrB),
        .imemData (dataB),
        .pcOut    (pcB),
        .instOut  (instB),
        .validOut (validB)
    );

    always @(posedge clock) begin
        dataA <= 8'hA0 + addrA;
        dataB <= 8'hA0 + addrB;
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic outA(input string tag, input logic v,
                        input logic [7:0] pc, input logic [7:0] inst);
        chk({tag, ".valid"}, {7'd0, validA}, {7'd0, v});
        if (v) begin
            chk({tag, ".pc"}, pcA, pc);
            chk({tag, ".inst"}, instA, inst);
        end
    endtask

    task automatic outB(input string tag, input logic v,
                        input logic [7:0] pc, input logic [7:0] inst);
        chk({tag, ".valid"}, {7'd0, validB}, {7'd0, v});
        if (v) begin
            chk({tag, ".pc"}, pcB, pc);
            chk({tag, ".inst"}, instB, inst);
        end
    endtask

    initial begin
        resetA = 1'b1; stallA = 1'b0; redirA = 1'b0; targetA = 8'h00;
        resetB = 1'b1; stallB = 1'b0; redirB = 1'b0; targetB = 8'h00;

        // reset state
        tick; tick;
        chk("rstA.valid", {7'd0, validA}, 8'd0);
        chk("rstA.pc", pcA, 8'h00);
        chk("rstA.inst", instA, 8'h00);
        chk("rstA.addr", addrA, 8'h00);

        // streaming after release
        resetA = 1'b0;
        tick; outA("fill", 1'b0, 8'h00, 8'h00);
        tick; outA("s0", 1'b1, 8'h00, 8'hA0);
        tick; outA("s1", 1'b1, 8'h01, 8'hA1);
        tick; outA("s2", 1'b1, 8'h02, 8'hA2);

        // three-cycle stall holds 02/A2
        stallA = 1'b1;
        tick; outA("st0", 1'b1, 8'h02, 8'hA2);
        tick; outA("st1", 1'b1, 8'h02, 8'hA2);
        tick; outA("st2", 1'b1, 8'h02, 8'hA2);
        stallA = 1'b0;
        tick; outA("rel0", 1'b1, 8'h03, 8'hA3);
        tick; outA("rel1", 1'b1, 8'h04, 8'hA4);

        // redirect to 40: two bubbles
        redirA = 1'b1; targetA = 8'h40;
        tick; outA("rd0", 1'b0, 8'h00, 8'h00);
        chk("rd0.addr", addrA, 8'h40);
        redirA = 1'b0;
        tick; outA("rd1", 1'b0, 8'h00, 8'h00);
        tick; outA("rd2", 1'b1, 8'h40, 8'hE0);
        tick; outA("rd3", 1'b1, 8'h41, 8'hE1);

        // redirect with stall: redirect wins
        redirA = 1'b1; stallA = 1'b1; targetA = 8'h80;
        tick; outA("rs0", 1'b0, 8'h00, 8'h00);
        chk("rs0.addr", addrA, 8'h80);
        redirA = 1'b0;
        tick; outA("rs1", 1'b0, 8'h00, 8'h00);
        stallA = 1'b0;
        tick; outA("rs2", 1'b0, 8'h00, 8'h00);
        tick; outA("rs3", 1'b1, 8'h80, 8'h20);
        tick; outA("rs4", 1'b1, 8'h81, 8'h21);

        // stall right after FILL->RUN
        resetA = 1'b1;
        tick; outA("rst2", 1'b0, 8'h00, 8'h00);
        chk("rst2.pc", pcA, 8'h00);
        resetA = 1'b0;
        tick; outA("ef0", 1'b0, 8'h00, 8'h00);
        stallA = 1'b1;
        tick; outA("ef1", 1'b0, 8'h00, 8'h00);
        stallA = 1'b0;
        tick; outA("ef2", 1'b1, 8'h00, 8'hA0);
        tick; outA("ef3", 1'b1, 8'h01, 8'hA1);

        // RESET_PC = FE, wrap through FF -> 00
        resetB = 1'b0;
        tick; outB("wf", 1'b0, 8'h00, 8'h00);
        tick; outB("w0", 1'b1, 8'hFE, 8'h9E);
        tick; outB("w1", 1'b1, 8'hFF, 8'h9F);
        tick; outB("w2", 1'b1, 8'h00, 8'hA0);
        tick; outB("w3", 1'b1, 8'h01, 8'hA1);

        // mid-stream reset clears outputs
        resetB = 1'b1;
        tick;
        chk("wr.valid", {7'd0, validB}, 8'd0);
        chk("wr.pc", pcB, 8'h00);
        chk("wr.inst", instB, 8'h00);
        chk("wr.addr", addrB, 8'hFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
